ps2_rx_unit: RTL and testbench

//  Receives PS/2 device-to-host frames (keyboard or mouse) on the system clock.
//  - Synchronises and debounces the PS/2 clock, then shifts in 11-bit frames on falling edges.
//  - Presents each data byte with a one-cycle done strobe.
//  - rx_en lets a companion transmitter block reception while it owns the bus.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_rx_unit_filter.sv | 49 ++++
 rtl/ps2_rx_unit.sv | 122 ++++++++++++
 tb/tb_ps2_rx_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 shared types, frame constants and parity helper.
// Used by the receiver and the companion transmitter.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DPS,
    LOAD
  } ps2_rx_state_t;

  localparam int PS2_FRAME_BITS = 11;

  // Parity bit that makes data plus parity carry an odd number of ones.
  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_rx_unit_filter.sv
// PS/2 line conditioning: 2-FF synchronisers, clock debounce filter
// and a one-cycle falling-edge pulse on the filtered clock.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2d_sync,
  output logic fall
);

  logic [1:0]            c_sync;
  logic [1:0]            d_sync;
  logic [FILTER_LEN-1:0] filt;
  logic [FILTER_LEN-1:0] filt_n;
  logic                  f_clk;
  logic                  f_clk_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
      filt   <= '1;
      f_clk  <= 1'b1;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
      filt   <= filt_n;
      f_clk  <= f_clk_n;
    end
  end

  assign filt_n = {c_sync[1], filt[FILTER_LEN-1:1]};

  // Filtered clock only moves once the whole window agrees.
  always_comb begin
    f_clk_n = f_clk;
    if (&filt)
      f_clk_n = 1'b1;
    else if (~|filt)
      f_clk_n = 1'b0;
  end

  assign fall      = f_clk & ~f_clk_n;
  assign ps2d_sync = d_sync[1];

endmodule

// File: rtl/ps2_rx_unit.sv
// PS/2 device-to-host frame receiver.
// Optional start/parity/stop checking under PS2RX_PARITY_CHECK_EN.
module ps2_rx_unit
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic       rx_idle,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       parity_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef logic [TW-1:0] tmr_t;
  localparam tmr_t TMR_MAX = tmr_t'(TIMEOUT_CYCLES - 1);

  typedef logic [PS2_FRAME_BITS-1:0] frame_t;

  ps2_rx_state_t state;
  ps2_rx_state_t state_n;
  logic [3:0]    n_bits;
  logic [3:0]    n_bits_n;
  frame_t        shreg;
  frame_t        shreg_n;
  tmr_t          tmr;
  tmr_t          tmr_n;
  logic [7:0]    dout_r;
  logic          d_sync;
  logic          fall;
  logic          load;
  logic          frame_ok;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .ps2c     (ps2c),
    .ps2d     (ps2d),
    .ps2d_sync(d_sync),
    .fall     (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      n_bits <= '0;
      shreg  <= '0;
      tmr    <= '0;
      dout_r <= '0;
    end else begin
      state  <= state_n;
      n_bits <= n_bits_n;
      shreg  <= shreg_n;
      tmr    <= tmr_n;
      if (rx_done_tick)
        dout_r <= shreg[8:1];
    end
  end

  always_comb begin
    state_n  = state;
    n_bits_n = n_bits;
    shreg_n  = shreg;
    tmr_n    = tmr;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        tmr_n = '0;
        if (fall && rx_en) begin
          shreg_n  = {d_sync, shreg[PS2_FRAME_BITS-1:1]};
          n_bits_n = 4'd9;
          state_n  = DPS;
        end
      end
      DPS: begin
        if (fall) begin
          shreg_n = {d_sync, shreg[PS2_FRAME_BITS-1:1]};
          tmr_n   = '0;
          if (n_bits == 4'd0)
            state_n = LOAD;
          else
            n_bits_n = n_bits - 4'd1;
        end else if (tmr == TMR_MAX) begin
          tmr_n   = '0;
          state_n = IDLE;
        end else begin
          tmr_n = tmr + tmr_t'(1);
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef PS2RX_PARITY_CHECK_EN
  // shreg: [0]=start, [8:1]=data, [9]=parity, [10]=stop
  assign frame_ok = ~shreg[0] & shreg[10] &
                    (shreg[9] == ps2_odd_parity(shreg[8:1]));
  assign parity_err = load & ~frame_ok;
`else
  logic unused_start;
  assign unused_start = shreg[0];
  assign frame_ok     = 1'b1;
  assign parity_err   = 1'b0;
`endif

  assign rx_done_tick = load & frame_ok;
  assign rx_idle      = (state == IDLE);
  assign dout         = dout_r;

endmodule

// File: tb/tb_ps2_rx_unit.sv
// Self-checking bench for ps2_rx_unit: randomized PS/2 frames against
// a frame-level reference model (expected bytes, tick and error counts).
module tb_ps2_rx_unit;

  localparam int HALF = 40;
  localparam int TMO  = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic       rx_idle;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       parity_err;

  int n_vec = 0;
  int n_err = 0;

  int act_ticks = 0;
  int act_perr  = 0;
  int exp_ticks = 0;
  int exp_perr  = 0;
  logic [7:0] exp_dout = 8'h00;

  ps2_rx_unit #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .rx_en       (rx_en),
    .rx_idle     (rx_idle),
    .rx_done_tick(rx_done_tick),
    .dout        (dout),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_done_tick === 1'b1) act_ticks++;
      if (parity_err === 1'b1) act_perr++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    cyc(HALF / 2);
    ps2c = 1'b0;
    cyc(HALF);
    ps2c = 1'b1;
    cyc(HALF / 2);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d,
                                           input bit good);
    logic p;
    p = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    if (!good) p = ~p;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit good);
    logic [10:0] f;
    f = mk_frame(d, good);
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    ps2d = 1'b1;
    cyc(20);
  endtask

  // Reference: a complete, enabled frame yields a byte unless the
  // checker is built in and the frame parity is wrong.
  task automatic model_frame(input logic [7:0] d, input bit good);
`ifdef PS2RX_PARITY_CHECK_EN
    if (good) begin
      exp_ticks++;
      exp_dout = d;
    end else begin
      exp_perr++;
    end
`else
    exp_ticks++;
    exp_dout = d;
`endif
  endtask

  task automatic check_state(input string nm);
    @(negedge clk);
    n_vec++;
    if (act_ticks !== exp_ticks) begin
      n_err++;
      $display("FAIL %s ticks: got %0d want %0d", nm, act_ticks, exp_ticks);
    end
    n_vec++;
    if (dout !== exp_dout) begin
      n_err++;
      $display("FAIL %s dout: got %h want %h", nm, dout, exp_dout);
    end
    n_vec++;
    if (rx_idle !== 1'b1) begin
      n_err++;
      $display("FAIL %s rx_idle: got %b want 1", nm, rx_idle);
    end
    n_vec++;
    if (act_perr !== exp_perr) begin
      n_err++;
      $display("FAIL %s perr: got %0d want %0d", nm, act_perr, exp_perr);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(5);
    @(negedge clk);
    n_vec++;
    if ({rx_idle, rx_done_tick, parity_err} !== 3'b100) begin
      n_err++;
      $display("FAIL reset flags: got %b want 100",
               {rx_idle, rx_done_tick, parity_err});
    end
    n_vec++;
    if (dout !== 8'h00) begin
      n_err++;
      $display("FAIL reset dout: got %h want 00", dout);
    end
    rst = 1'b0;
    cyc(20);
  endtask

  task automatic test_single;
    rx_en = 1'b1;
    send_frame(8'hFA, 1'b1);
    model_frame(8'hFA, 1'b1);
    check_state("single_fa");
  endtask

  task automatic test_back_to_back;
    send_frame(8'hAA, 1'b1);
    model_frame(8'hAA, 1'b1);
    check_state("b2b_aa");
    send_frame(8'h00, 1'b1);
    model_frame(8'h00, 1'b1);
    check_state("b2b_00");
  endtask

  task automatic test_rx_en;
    logic [10:0] f;
    rx_en = 1'b0;
    send_frame(8'h55, 1'b1);
    rx_en = 1'b1;
    check_state("rx_en_low");
    f = mk_frame(8'h3C, 1'b1);
    send_bit(f[0]);
    rx_en = 1'b0;
    for (int i = 1; i < 11; i++) send_bit(f[i]);
    cyc(20);
    model_frame(8'h3C, 1'b1);
    rx_en = 1'b1;
    check_state("rx_en_mid_drop");
  endtask

  task automatic test_glitch;
    int w[2] = '{3, 7};
    foreach (w[k]) begin
      ps2c = 1'b0;
      cyc(w[k]);
      ps2c = 1'b1;
      cyc(HALF);
      check_state($sformatf("glitch_%0d", w[k]));
    end
  endtask

  task automatic test_timeout;
    logic [10:0] f;
    f = mk_frame(8'h55, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(f[i]);
    ps2d = 1'b1;
    cyc(1800);
    @(negedge clk);
    n_vec++;
    if (rx_idle !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early rx_idle: got %b want 0", rx_idle);
    end
    cyc(300);
    check_state("timeout_abandon");
    send_frame(8'h55, 1'b1);
    model_frame(8'h55, 1'b1);
    check_state("timeout_next");
  endtask

  task automatic test_parity;
    send_frame(8'hAA, 1'b0);
    model_frame(8'hAA, 1'b0);
    check_state("bad_parity_aa");
  endtask

  task automatic test_random;
    logic [7:0] d;
    bit g;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      g = ($urandom_range(0, 3) != 0);
      send_frame(d, g);
      model_frame(d, g);
      check_state($sformatf("random_%0d", i));
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [10:0] f;
    f = mk_frame(8'hC3, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(f[i]);
    @(negedge clk);
    n_vec++;
    if (rx_idle !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid busy: got %b want 0", rx_idle);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_dout = 8'h00;
    n_vec++;
    if (rx_idle !== 1'b1 || dout !== 8'h00) begin
      n_err++;
      $display("FAIL rst_mid outputs: got idle=%b dout=%h want 1/00",
               rx_idle, dout);
    end
    rst = 1'b0;
    ps2d = 1'b1;
    cyc(100);
    check_state("rst_mid_after");
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_rx_en;
    test_glitch;
    test_timeout;
    test_parity;
    test_random;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
